// File: rtl/setup_decoder.sv
// setup_decoder: snapshots the 8-bit setup byte on a load pulse, splits it
// into level / map / round-limit fields, then paces the game with a
// level-dependent tick and counts completed rounds until the limit is hit.
module setup_decoder #(
    parameter int PERIOD0 = 8,
    parameter int PERIOD1 = 6,
    parameter int PERIOD2 = 4,
    parameter int PERIOD3 = 2,
    parameter int CNT_W   = 28
) (
    input  logic       clk,
    input  logic       R,
    input  logic       load,
    input  logic [7:0] setup,
    input  logic       run,
    output logic [1:0] level,
    output logic [1:0] map,
    output logic [4:0] rounds_max,
    output logic [4:0] round_cnt,
    output logic       tick,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOADED  = 2'd1,
        S_RUNNING = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Terminal divider counts, one per level (period minus one).
    localparam logic [CNT_W-1:0] LIM0 = CNT_W'(PERIOD0 - 1);
    localparam logic [CNT_W-1:0] LIM1 = CNT_W'(PERIOD1 - 1);
    localparam logic [CNT_W-1:0] LIM2 = CNT_W'(PERIOD2 - 1);
    localparam logic [CNT_W-1:0] LIM3 = CNT_W'(PERIOD3 - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] divider;
    logic [CNT_W-1:0] div_lim;
    logic             div_wrap;
    logic             last_round;
    logic             capture;

    // A rounds field of zero means the maximum of sixteen rounds.
    function automatic logic [4:0] decode_rounds(input logic [3:0] raw);
        if (raw == 4'd0) begin
            return 5'd16;
        end
        return {1'b0, raw};
    endfunction

    // Divider terminal count for the given level; level 3 is fastest.
    function automatic logic [CNT_W-1:0] period_limit(input logic [1:0] lv);
        case (lv)
            2'd0:    return LIM0;
            2'd1:    return LIM1;
            2'd2:    return LIM2;
            default: return LIM3;
        endcase
    endfunction

    // Decode the per-cycle conditions shared by the FSM and the datapath.
    always_comb begin
        div_lim    = period_limit(level);
        div_wrap   = (state_q == S_RUNNING) && run && (divider == div_lim);
        last_round = div_wrap && ((round_cnt + 5'd1) == rounds_max);
        capture    = load && (state_q != S_RUNNING);
    end

    // State register; reset aborts any run immediately.
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; load always wins over run outside RUNNING.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    state_d = S_LOADED;
                end
            end
            S_LOADED: begin
                if (load) begin
                    state_d = S_LOADED;
                end else if (run) begin
                    state_d = S_RUNNING;
                end
            end
            S_RUNNING: begin
                if (last_round) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (load) begin
                    state_d = S_LOADED;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs follow the state directly, so reset clears them at once.
    always_comb begin
        busy = (state_q == S_RUNNING);
        done = (state_q == S_DONE);
    end

    // Field capture, tick divider and round counter.
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            level      <= 2'd0;
            map        <= 2'd0;
            rounds_max <= 5'd0;
            round_cnt  <= 5'd0;
            divider    <= '0;
            tick       <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (capture) begin
                level      <= setup[7:6];
                map        <= setup[5:4];
                rounds_max <= decode_rounds(setup[3:0]);
                round_cnt  <= 5'd0;
                divider    <= '0;
            end else if (state_q == S_LOADED && run) begin
                divider <= '0;
            end else if (state_q == S_RUNNING && run) begin
                if (div_wrap) begin
                    divider   <= '0;
                    tick      <= 1'b1;
                    round_cnt <= round_cnt + 5'd1;
                end else begin
                    divider <= divider + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/setup_decoder.md
Name: setup_decoder

Overview:
- Consumer side of the 8-bit setup byte captured during the Setup state.
- On a load pulse it snapshots the setup byte and splits it into three fields: level, map and number of rounds.
- While the game runs, it generates the level-dependent game tick and counts rounds up to the configured maximum, then flags completion.
- Sits between the setup register and the game datapath/FSM.

Parameters:
PERIOD0, 8, tick period in clk cycles for level 0 (slowest); synthesis overrides to 200_000_000
PERIOD1, 6, tick period for level 1; synthesis 150_000_000
PERIOD2, 4, tick period for level 2; synthesis 100_000_000
PERIOD3, 2, tick period for level 3 (fastest); synthesis 50_000_000
CNT_W, 28, divider width; must hold max(PERIODx)-1

Ports:
clk  in  1  clock
R  in  1  reset, asynchronous, active-low
load  in  1  single-cycle pulse: capture setup
setup  in  8  [7:6] level, [5:4] map, [3:0] rounds
run  in  1  level: game running (pause when low)
level  out  2  latched level
map  out  2  latched map select
rounds_max  out  5  decoded round limit, 1..16
round_cnt  out  5  completed rounds
tick  out  1  one-cycle game tick pulse
busy  out  1  high in RUNNING
done  out  1  high in DONE

Behaviour:
- Reset (R=0, async): state=IDLE; level=0, map=0, rounds_max=0, round_cnt=0, divider=0, tick=0, busy=0, done=0. Reset asserted mid-run aborts immediately; no tick is emitted.
- All other updates occur on the rising edge of clk.
- States: IDLE, LOADED, RUNNING, DONE.
- IDLE / DONE, load=1:
  - level<=setup[7:6], map<=setup[5:4].
  - rounds_max<=(setup[3:0]==0) ? 16 : setup[3:0].
  - round_cnt<=0, divider<=0, done<=0.
  - Next state LOADED. Fields are visible on the cycle after load.
- LOADED:
  - load=1 recaptures all fields and stays in LOADED.
  - run=1 (with load=0) -> RUNNING, divider<=0.
  - load and run together: load wins; stay LOADED.
- RUNNING: busy=1; load is ignored.
  - run=1: divider increments each cycle.
  - When divider==PERIOD[level]-1: divider<=0, tick=1 for exactly that one cycle (registered), round_cnt<=round_cnt+1.
  - run=0: divider and round_cnt hold and tick=0 (pause). Resuming continues from the held divider value.
  - If the tick increments round_cnt to rounds_max: on that same edge go to DONE, done<=1, busy<=0.
- Tick timing: the first tick occurs PERIOD[level] cycles after entering RUNNING. Inter-tick spacing while run=1 is exactly PERIOD[level] cycles.
- DONE: done=1, tick=0. Outputs hold until load or reset. load -> LOADED as in IDLE.
- Widths and wrap: round_cnt never exceeds rounds_max, so it never wraps. The divider never exceeds PERIODx-1. level cannot change during RUNNING.

Test Plan:
- Reset then load with setup=8'hE5 -> next cycle: level=3, map=2, rounds_max=5, round_cnt=0, state LOADED, busy=0, done=0.
- Load setup=8'h03, hold run=1 -> tick pulses every 8 cycles (first at 8th cycle in RUNNING); after the 3rd tick, done=1, busy=0, round_cnt=3, no further ticks.
- Load setup=8'hC0 (rounds=0), run=1 -> rounds_max=16; ticks every 2 cycles; done after 16 ticks with round_cnt=16.
- Level 1 run: drop run for 10 cycles after 3 RUNNING cycles -> no tick during pause; next tick arrives 3 cycles after run returns (6-cycle period preserved).
- Pulse load during RUNNING with a different setup -> fields unchanged, counting continues. Load in DONE -> new fields, round_cnt=0, done=0.
- Assert R low mid-divider in RUNNING, asynchronously between edges -> all outputs 0 immediately, state IDLE. After release, run=1 without load stays IDLE with no ticks.
